// File: rtl/stm32_spi_bridge_v2.sv
// stm32_spi_bridge_v2 : SPI slave (all four modes) to internal register bus.
// Frame = 16-bit command followed by DATA_W-bit words, MSB first. Supports
// burst writes / reads with address auto-increment, read prefetch with a
// bus timeout, and a MISO output enable tied to the synchronised chip select.
module stm32_spi_bridge_v2 #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int BUS_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              bus_write,
   output logic              bus_read,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ready,
   output logic              busy,
   output logic              err_timeout,
   output logic [7:0]        err_count
);

   localparam int RXW = (DATA_W > 16) ? DATA_W : 16;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_WDATA  = 3'd2;
   localparam logic [2:0] S_RFETCH = 3'd3;
   localparam logic [2:0] S_RDATA  = 3'd4;

   localparam logic [5:0]  CMD_LAST  = 6'd15;
   localparam logic [5:0]  WORD_LAST = 6'(DATA_W - 1);
   localparam logic [15:0] TMO_LAST  = 16'(BUS_TIMEOUT - 1);
   localparam logic        SCLK_IDLE = (CPOL != 0);

   // synchroniser and edge-detect flops
   logic sclk_m_q, sclk_s_q, sclk_p_q;
   logic cs_m_q, cs_s_q;
   logic mosi_m_q, mosi_s_q;

   // frame state
   logic [2:0]        state_q, state_d;
   logic [5:0]        bitcnt_q, bitcnt_d;
   logic [RXW-2:0]    rx_q, rx_d;
   logic              inc_q, inc_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              miso_q, miso_d;
   logic              skip_q, skip_d;

   // bus side
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_pend_q, wr_pend_d;
   logic              write_q, write_d;
   logic              read_q, read_d;
   logic              issued_q, issued_d;
   logic [15:0]       tmo_q, tmo_d;
   logic [DATA_W-1:0] pref_q, pref_d;
   logic              err_q, err_d;
   logic [7:0]        errc_q, errc_d;

   logic              rise, fall, sample_edge, shift_edge, cs_act;
   logic [RXW-1:0]    rx_next;

   // two-flop synchronisers; a third sclk flop gives edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m_q <= SCLK_IDLE;
         sclk_s_q <= SCLK_IDLE;
         sclk_p_q <= SCLK_IDLE;
         cs_m_q   <= 1'b1;
         cs_s_q   <= 1'b1;
         mosi_m_q <= 1'b0;
         mosi_s_q <= 1'b0;
      end else begin
         sclk_m_q <= spi_sclk;
         sclk_s_q <= sclk_m_q;
         sclk_p_q <= sclk_s_q;
         cs_m_q   <= spi_cs_n;
         cs_s_q   <= cs_m_q;
         mosi_m_q <= spi_mosi;
         mosi_s_q <= mosi_m_q;
      end
   end

   assign rise        = sclk_s_q & ~sclk_p_q;
   assign fall        = ~sclk_s_q & sclk_p_q;
   assign sample_edge = (CPOL == CPHA) ? rise : fall;
   assign shift_edge  = (CPOL == CPHA) ? fall : rise;
   assign cs_act      = ~cs_s_q;
   assign rx_next     = {rx_q, mosi_s_q};

   // frame sequencing, bus strobes, prefetch and timeout handling
   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      rx_d      = rx_q;
      inc_d     = inc_q;
      tx_d      = tx_q;
      miso_d    = miso_q;
      skip_d    = skip_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_pend_d = 1'b0;
      write_d   = wr_pend_q;
      read_d    = 1'b0;
      issued_d  = issued_q;
      tmo_d     = tmo_q;
      pref_d    = pref_q;
      err_d     = 1'b0;
      errc_d    = errc_q;

      // write address advances only after the strobe has been seen with it
      if (write_q && inc_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      if (!cs_act) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d  = S_CMD;
               bitcnt_d = '0;
               tx_d     = '0;
               miso_d   = 1'b0;
               skip_d   = 1'b0;
            end
            S_CMD: begin
               if (sample_edge) begin
                  rx_d = rx_next[RXW-2:0];
                  if (bitcnt_q == CMD_LAST) begin
                     bitcnt_d = '0;
                     addr_d   = rx_next[ADDR_W-1:0];
                     inc_d    = rx_next[14];
                     if (rx_next[15]) begin
                        state_d  = S_RFETCH;
                        issued_d = 1'b0;
                     end else begin
                        state_d = S_WDATA;
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + 6'd1;
                  end
               end
            end
            S_WDATA: begin
               if (sample_edge) begin
                  rx_d = rx_next[RXW-2:0];
                  if (bitcnt_q == WORD_LAST) begin
                     bitcnt_d  = '0;
                     wdata_d   = rx_next[DATA_W-1:0];
                     wr_pend_d = 1'b1;
                  end else begin
                     bitcnt_d = bitcnt_q + 6'd1;
                  end
               end
            end
            S_RFETCH, S_RDATA: begin
               // word boundary: hand the prefetched word to the TX shifter
               if (sample_edge) begin
                  if (bitcnt_q == WORD_LAST) begin
                     bitcnt_d = '0;
                     tx_d     = pref_q;
                     skip_d   = (CPHA == 0);
                     if (state_q == S_RDATA) begin
                        state_d  = S_RFETCH;
                        issued_d = 1'b0;
                        if (inc_q) begin
                           addr_d = addr_q + ADDR_W'(1);
                        end
                     end
                  end else begin
                     bitcnt_d = bitcnt_q + 6'd1;
                  end
               end
               // background fetch: strobe once, then wait for ready or timeout
               if (state_q == S_RFETCH) begin
                  if (!issued_q) begin
                     read_d   = 1'b1;
                     issued_d = 1'b1;
                     tmo_d    = '0;
                  end else if (!read_q) begin
                     if (bus_ready) begin
                        pref_d  = bus_rdata;
                        state_d = S_RDATA;
                     end else if (tmo_q == TMO_LAST) begin
                        pref_d  = '1;
                        err_d   = 1'b1;
                        state_d = S_RDATA;
                        if (errc_q != 8'hFF) begin
                           errc_d = errc_q + 8'd1;
                        end
                     end else begin
                        tmo_d = tmo_q + 16'd1;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase

         // CPHA=0 keeps the freshly loaded MSB across the trailing edge of
         // the previous word's last bit; CPHA=1 presents it on the next edge.
         if (state_q != S_IDLE && shift_edge) begin
            if (CPHA != 0) begin
               miso_d = tx_q[DATA_W-1];
               tx_d   = tx_q << 1;
            end else if (skip_q) begin
               skip_d = 1'b0;
            end else begin
               tx_d = tx_q << 1;
            end
         end
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bitcnt_q  <= '0;
         rx_q      <= '0;
         inc_q     <= 1'b0;
         tx_q      <= '0;
         miso_q    <= 1'b0;
         skip_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_pend_q <= 1'b0;
         write_q   <= 1'b0;
         read_q    <= 1'b0;
         issued_q  <= 1'b0;
         tmo_q     <= '0;
         pref_q    <= '0;
         err_q     <= 1'b0;
         errc_q    <= '0;
      end else begin
         state_q   <= state_d;
         bitcnt_q  <= bitcnt_d;
         rx_q      <= rx_d;
         inc_q     <= inc_d;
         tx_q      <= tx_d;
         miso_q    <= miso_d;
         skip_q    <= skip_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_pend_q <= wr_pend_d;
         write_q   <= write_d;
         read_q    <= read_d;
         issued_q  <= issued_d;
         tmo_q     <= tmo_d;
         pref_q    <= pref_d;
         err_q     <= err_d;
         errc_q    <= errc_d;
      end
   end

   assign spi_miso_oe = cs_act;
   assign spi_miso    = cs_act & ((CPHA != 0) ? miso_q : tx_q[DATA_W-1]);
   assign bus_write   = write_q;
   assign bus_read    = read_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign busy        = cs_act & (state_q != S_IDLE);
   assign err_timeout = err_q;
   assign err_count   = errc_q;

endmodule

// File: tb/tb_stm32_spi_bridge_v2.sv
// Directed bench for stm32_spi_bridge_v2: five instances cover the four SPI
// modes, a short bus timeout and a 4-bit address wrap.
module tb_stm32_spi_bridge_v2;

   localparam int HALF = 50;

   logic        clk, rst_n, sclk, mosi;
   logic [4:0]  cs_n;
   logic        miso_w [5];
   logic        oe_w   [5];
   logic        wr_w   [5];
   logic        rd_w   [5];
   logic        busy_w [5];
   logic        tmo_w  [5];
   logic [7:0]  ec_w   [5];
   logic [31:0] wd_w   [5];
   logic [11:0] av     [5];
   logic [3:0]  addr4;
   logic [31:0] rdata2;
   logic        ready2;
   logic        miso_sel;

   int n_checks, n_fail;
   int sel, cpol_m, cpha_m;
   int cyc, cnt2, both_cnt, tmo_pulses, last_rd3, first_tmo3;
   logic [7:0]  ec_at_first;
   int          wcnt [5];
   int          rcnt [5];
   logic [11:0] wa   [5][8];
   logic [31:0] wdv  [5][8];

   assign av[4]    = {8'h0, addr4};
   assign miso_sel = miso_w[sel];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   stm32_spi_bridge_v2 #(.CPOL(0), .CPHA(0)) u0 (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n[0]),
      .spi_miso(miso_w[0]), .spi_miso_oe(oe_w[0]), .bus_write(wr_w[0]), .bus_read(rd_w[0]),
      .bus_addr(av[0]), .bus_wdata(wd_w[0]), .bus_rdata(32'h0), .bus_ready(1'b0),
      .busy(busy_w[0]), .err_timeout(tmo_w[0]), .err_count(ec_w[0]));

   stm32_spi_bridge_v2 #(.CPOL(1), .CPHA(1)) u1 (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n[1]),
      .spi_miso(miso_w[1]), .spi_miso_oe(oe_w[1]), .bus_write(wr_w[1]), .bus_read(rd_w[1]),
      .bus_addr(av[1]), .bus_wdata(wd_w[1]), .bus_rdata(32'h0), .bus_ready(1'b0),
      .busy(busy_w[1]), .err_timeout(tmo_w[1]), .err_count(ec_w[1]));

   stm32_spi_bridge_v2 #(.CPOL(0), .CPHA(1)) u2 (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n[2]),
      .spi_miso(miso_w[2]), .spi_miso_oe(oe_w[2]), .bus_write(wr_w[2]), .bus_read(rd_w[2]),
      .bus_addr(av[2]), .bus_wdata(wd_w[2]), .bus_rdata(rdata2), .bus_ready(ready2),
      .busy(busy_w[2]), .err_timeout(tmo_w[2]), .err_count(ec_w[2]));

   stm32_spi_bridge_v2 #(.CPOL(1), .CPHA(0), .BUS_TIMEOUT(10)) u3 (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n[3]),
      .spi_miso(miso_w[3]), .spi_miso_oe(oe_w[3]), .bus_write(wr_w[3]), .bus_read(rd_w[3]),
      .bus_addr(av[3]), .bus_wdata(wd_w[3]), .bus_rdata(32'h0), .bus_ready(1'b0),
      .busy(busy_w[3]), .err_timeout(tmo_w[3]), .err_count(ec_w[3]));

   stm32_spi_bridge_v2 #(.ADDR_W(4), .CPOL(0), .CPHA(0)) u4 (
      .clk(clk), .rst_n(rst_n), .spi_sclk(sclk), .spi_mosi(mosi), .spi_cs_n(cs_n[4]),
      .spi_miso(miso_w[4]), .spi_miso_oe(oe_w[4]), .bus_write(wr_w[4]), .bus_read(rd_w[4]),
      .bus_addr(addr4), .bus_wdata(wd_w[4]), .bus_rdata(32'h0), .bus_ready(1'b0),
      .busy(busy_w[4]), .err_timeout(tmo_w[4]), .err_count(ec_w[4]));

   // bus monitor and read responder for u2 (ready 3 clk after bus_read)
   initial begin
      cyc = 0; cnt2 = 0; both_cnt = 0; tmo_pulses = 0; last_rd3 = 0; first_tmo3 = -1;
      ec_at_first = '0; ready2 = 1'b0; rdata2 = '0;
      for (int k = 0; k < 5; k++) begin
         wcnt[k] = 0;
         rcnt[k] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < 5; k++) begin
            if (wr_w[k] && rd_w[k]) both_cnt++;
            if (wr_w[k]) begin
               if (wcnt[k] < 8) begin
                  wa[k][wcnt[k]]  = av[k];
                  wdv[k][wcnt[k]] = wd_w[k];
               end
               wcnt[k]++;
            end
            if (rd_w[k]) rcnt[k]++;
         end
         if (rd_w[3]) last_rd3 = cyc;
         if (tmo_w[3]) begin
            tmo_pulses++;
            if (tmo_pulses == 1) begin
               first_tmo3  = cyc - last_rd3;
               ec_at_first = ec_w[3];
            end
         end
         ready2 = 1'b0;
         if (rd_w[2]) begin
            cnt2   = 3;
            rdata2 = 32'h1000 + {20'h0, av[2]};
         end else if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) ready2 = 1'b1;
         end
      end
   end

   task automatic frame_begin(input int k, input int cpol, input int cpha);
      @(negedge clk);
      sel = k; cpol_m = cpol; cpha_m = cpha;
      sclk = (cpol != 0);
      mosi = 1'b0;
      #200;
      cs_n[k] = 1'b0;
      #200;
   endtask

   task automatic frame_end(input int k);
      #HALF;
      cs_n[k] = 1'b1;
      #300;
   endtask

   task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (cpha_m == 0) begin
            mosi = val[i];
            #HALF; sclk = (cpol_m == 0); rx = {rx[30:0], miso_sel};
            #HALF; sclk = (cpol_m != 0);
         end else begin
            sclk = (cpol_m == 0); mosi = val[i];
            #HALF; sclk = (cpol_m != 0); rx = {rx[30:0], miso_sel};
            #HALF;
         end
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = '1;
      #23;
      for (int k = 0; k < 5; k++) begin
         if ({wr_w[k], rd_w[k], busy_w[k], oe_w[k], miso_w[k], tmo_w[k]} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags[%0d]: got %b required 000000", k,
               {wr_w[k], rd_w[k], busy_w[k], oe_w[k], miso_w[k], tmo_w[k]});
         end
         n_checks++;
         if ({av[k], wd_w[k], ec_w[k]} !== 52'h0) begin
            n_fail++; $display("FAIL reset_regs[%0d]: addr %h wdata %h errcnt %h required 0", k, av[k], wd_w[k], ec_w[k]);
         end
         n_checks++;
      end
      #27 rst_n = 1'b1;
      #100;
   endtask

   task automatic test_mode0_write;
      logic [31:0] rx;
      frame_begin(0, 0, 0);
      if ({busy_w[0], oe_w[0]} !== 2'b11) begin
         n_fail++; $display("FAIL t1_busy_oe: got %b required 11", {busy_w[0], oe_w[0]});
      end
      n_checks++;
      spi_bits(32'h0010, 16, rx);
      spi_bits(32'hA5A5_1234, 32, rx);
      frame_end(0);
      if (rx !== 32'h0) begin n_fail++; $display("FAIL t1_miso_quiet: got %h required 0", rx); end
      n_checks++;
      if (wcnt[0] !== 1) begin n_fail++; $display("FAIL t1_wcount: got %0d required 1", wcnt[0]); end
      n_checks++;
      if (wa[0][0] !== 12'h010 || wdv[0][0] !== 32'hA5A5_1234) begin
         n_fail++; $display("FAIL t1_write: got %h/%h required 010/a5a51234", wa[0][0], wdv[0][0]);
      end
      n_checks++;
      if ({busy_w[0], oe_w[0]} !== 2'b00) begin
         n_fail++; $display("FAIL t1_idle: got %b required 00", {busy_w[0], oe_w[0]});
      end
      n_checks++;
   endtask

   task automatic test_burst_write;
      logic [31:0] rx;
      logic [31:0] words [3];
      words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
      frame_begin(1, 1, 1);
      spi_bits(32'h4020, 16, rx);
      for (int i = 0; i < 3; i++) spi_bits(words[i], 32, rx);
      spi_bits(32'h0000_03FF, 10, rx);
      frame_end(1);
      if (wcnt[1] !== 3) begin n_fail++; $display("FAIL t2_wcount: got %0d required 3", wcnt[1]); end
      n_checks++;
      for (int i = 0; i < 3; i++) begin
         if (wa[1][i] !== 12'h020 + 12'(i) || wdv[1][i] !== words[i]) begin
            n_fail++; $display("FAIL t2_write[%0d]: got %h/%h required %h/%h", i, wa[1][i], wdv[1][i],
               12'h020 + 12'(i), words[i]);
         end
         n_checks++;
      end
      if (av[1] !== 12'h023) begin n_fail++; $display("FAIL t2_addr_end: got %h required 023", av[1]); end
      n_checks++;
   endtask

   task automatic test_read_inc;
      logic [31:0] rx [3];
      logic [31:0] exp_w [3];
      int rbefore;
      exp_w[0] = 32'h0; exp_w[1] = 32'h1100; exp_w[2] = 32'h1101;
      rbefore = rcnt[2];
      frame_begin(2, 0, 1);
      spi_bits(32'hC100, 16, rx[0]);
      for (int i = 0; i < 3; i++) spi_bits(32'h0, 32, rx[i]);
      frame_end(2);
      for (int i = 0; i < 3; i++) begin
         if (rx[i] !== exp_w[i]) begin
            n_fail++; $display("FAIL t3_miso[%0d]: got %h required %h", i, rx[i], exp_w[i]);
         end
         n_checks++;
      end
      if (rcnt[2] - rbefore !== 4) begin
         n_fail++; $display("FAIL t3_reads: got %0d required 4", rcnt[2] - rbefore);
      end
      n_checks++;
      if (av[2] !== 12'h103) begin n_fail++; $display("FAIL t3_addr_end: got %h required 103", av[2]); end
      n_checks++;
   endtask

   task automatic test_timeout;
      logic [31:0] rx0, rx1;
      frame_begin(3, 1, 0);
      spi_bits(32'h8055, 16, rx0);
      spi_bits(32'h0, 32, rx0);
      spi_bits(32'h0, 32, rx1);
      frame_end(3);
      if (rx0 !== 32'h0) begin n_fail++; $display("FAIL t4_dummy: got %h required 0", rx0); end
      n_checks++;
      if (rx1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL t4_word: got %h required ffffffff", rx1); end
      n_checks++;
      if (first_tmo3 !== 11) begin n_fail++; $display("FAIL t4_tmo_delay: got %0d required 11", first_tmo3); end
      n_checks++;
      if (ec_at_first !== 8'd1) begin n_fail++; $display("FAIL t4_errcnt_first: got %0d required 1", ec_at_first); end
      n_checks++;
      if (tmo_pulses !== 2 || ec_w[3] !== 8'd2) begin
         n_fail++; $display("FAIL t4_errcnt_end: pulses %0d count %0d required 2/2", tmo_pulses, ec_w[3]);
      end
      n_checks++;
      if (av[3] !== 12'h055) begin n_fail++; $display("FAIL t4_addr_hold: got %h required 055", av[3]); end
      n_checks++;
   endtask

   task automatic test_wrap;
      logic [31:0] rx;
      frame_begin(4, 0, 0);
      spi_bits(32'h400F, 16, rx);
      spi_bits(32'h1111_1111, 32, rx);
      spi_bits(32'h2222_2222, 32, rx);
      frame_end(4);
      if (wcnt[4] !== 2) begin n_fail++; $display("FAIL t5_wcount: got %0d required 2", wcnt[4]); end
      n_checks++;
      if (wa[4][0] !== 12'h00F || wa[4][1] !== 12'h000) begin
         n_fail++; $display("FAIL t5_wrap_addr: got %h,%h required 00f,000", wa[4][0], wa[4][1]);
      end
      n_checks++;
      if (wdv[4][1] !== 32'h2222_2222) begin n_fail++; $display("FAIL t5_wdata: got %h required 22222222", wdv[4][1]); end
      n_checks++;
      if (addr4 !== 4'h1) begin n_fail++; $display("FAIL t5_addr_end: got %h required 1", addr4); end
      n_checks++;
   endtask

   task automatic test_reset_midframe;
      logic [31:0] rx;
      int wbefore;
      frame_begin(0, 0, 0);
      spi_bits(32'h4030, 16, rx);
      spi_bits(32'h0000_ABCD, 16, rx);
      @(negedge clk);
      wbefore = wcnt[0];
      rst_n = 1'b0;
      #1;
      if ({busy_w[0], oe_w[0], miso_w[0], wr_w[0]} !== 4'b0) begin
         n_fail++; $display("FAIL t6_flags: got %b required 0000", {busy_w[0], oe_w[0], miso_w[0], wr_w[0]});
      end
      n_checks++;
      if (av[0] !== 12'h0 || wd_w[0] !== 32'h0 || ec_w[3] !== 8'h0) begin
         n_fail++; $display("FAIL t6_regs: addr %h wdata %h errcnt %h required 0", av[0], wd_w[0], ec_w[3]);
      end
      n_checks++;
      cs_n[0] = 1'b1;
      #99 rst_n = 1'b1;
      repeat (30) @(negedge clk);
      if (wcnt[0] !== wbefore) begin n_fail++; $display("FAIL t6_no_strobe: got %0d required %0d", wcnt[0], wbefore); end
      n_checks++;
      frame_begin(0, 0, 0);
      spi_bits(32'h0044, 16, rx);
      spi_bits(32'hDEAD_BEEF, 32, rx);
      frame_end(0);
      if (wcnt[0] !== wbefore + 1 || wa[0][wbefore] !== 12'h044 || wdv[0][wbefore] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL t6_clean_frame: count %0d addr %h data %h required %0d/044/deadbeef",
            wcnt[0], wa[0][wbefore], wdv[0][wbefore], wbefore + 1);
      end
      n_checks++;
   endtask

   task automatic test_strobe_exclusive;
      if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d required 0", both_cnt); end
      n_checks++;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      sel = 0; cpol_m = 0; cpha_m = 0;
      test_reset();
      test_mode0_write();
      test_burst_write();
      test_read_inc();
      test_timeout();
      test_wrap();
      test_reset_midframe();
      test_strobe_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
